alu_issue_unit: RTL and testbench

Command front-end for the 8-bit ALU. It buffers operation commands in a small FIFO, issues them one at a time to the combinational ALU over registered operand/opcode lines, and captures result, carry and zero into a response register. Both the command and response sides use valid/ready handshakes. An accumulator holds the last captured result and can stand in for operand A, so dependent operations chain without a round trip through the host.

---
 rtl/alu_issue_unit.sv | 136 +++++++++++++
 tb/tb_alu_issue_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU commands, issues one at a time on registered lines, captures result and flags.
// Latency: response visible two cycles after a command is accepted into an empty, idle unit.
// Backpressure: rsp_ready low holds the response and stalls issue; the FIFO accepts commands until full.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_opcode,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic                     cmd_use_acc,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic [WIDTH-1:0]         acc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;
  logic [WIDTH-1:0] issue_a;
  state_t           state;

  // Full check uses the registered count only, so cmd_ready has no path from cmd_valid.
  assign cmd_ready     = (fifo_count != FULL_CNT) && !rst;
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (fifo_count != '0);
  // Pop from IDLE, or on the response handshake so RESP chains straight into DRIVE.
  assign pop           = fifo_nonempty &&
                         ((state == IDLE) || ((state == RESP) && rsp_valid && rsp_ready));
  assign head          = mem[rd_ptr];
  // acc already holds the previous op's result: a pop never precedes that op's capture.
  assign issue_a       = head.use_acc ? acc : head.a;

  // Command storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    end
  end

  // FIFO pointers (wrap modulo DEPTH) and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue/capture sequencer with registered ALU operands, response and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a      <= issue_a;
            alu_b      <= head.b;
            alu_opcode <= head.opcode;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          acc        <= alu_result;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a      <= issue_a;
              alu_b      <= head.b;
              alu_opcode <= head.opcode;
              state      <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed plus random stimulus, scoreboard of expected responses against a reference model.
// Latency: responses are matched whenever a handshake is observed, so timing checks use logged cycle stamps.
// Backpressure: rsp_ready is held low in directed phases and randomized in the random phase.
module tb_alu_issue_unit;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_opcode;
  logic [WIDTH-1:0]       cmd_a;
  logic [WIDTH-1:0]       cmd_b;
  logic                   cmd_use_acc;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [2:0]             alu_opcode;
  logic [WIDTH-1:0]       alu_result;
  logic                   alu_carry;
  logic                   alu_zero;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_carry;
  logic                   rsp_zero;
  logic [WIDTH-1:0]       acc;
  logic [$clog2(DEPTH):0] fifo_count;

  alu_issue_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: {carry, result}; SUB carry is the borrow, shifts carry out the dropped bit.
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = '0;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, 1'b0};
      default: r = {a[0], 1'b0, a[7:1]};
    endcase
    return r;
  endfunction

  logic [8:0] alu_out;
  assign alu_out    = alu_ref(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_out[7:0];
  assign alu_carry  = alu_out[8];
  assign alu_zero   = (alu_out[7:0] == 8'h00);

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] acc;
    logic [7:0] a;
    logic       c;
    logic       z;
    int         cyc;
  } log_t;

  exp_t       exp_q[$];
  log_t       log_q[$];
  logic [7:0] acc_model = 8'h00;
  int         total = 0;
  int         bad = 0;
  int         last_acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, want);
    end
  endtask

  // Reference model: commands execute strictly in acceptance order, so the operand A
  // substitution and the expected result are known the moment a command is accepted.
  task automatic model_push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    exp_t e;
    logic [8:0] r;
    e.op  = op;
    e.a   = ua ? acc_model : a;
    e.b   = b;
    r     = alu_ref(op, e.a, b);
    e.res = r[7:0];
    e.c   = r[8];
    e.z   = (r[7:0] == 8'h00);
    acc_model = r[7:0];
    exp_q.push_back(e);
  endtask

  // Monitor: checks every accepted response against the scoreboard and that held responses stay put.
  exp_t       mon_e;
  log_t       mon_l;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_res = 8'h00;
  logic       prev_c = 1'b0;
  logic       prev_z = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_result", 32'(rsp_result), 32'(prev_res));
        chk("hold_flags", 32'({rsp_carry, rsp_zero}), 32'({prev_c, prev_z}));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp got=%0h exp=none", rsp_result);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          chk("rsp_carry", 32'(rsp_carry), 32'(mon_e.c));
          chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.z));
          chk("acc", 32'(acc), 32'(mon_e.res));
          chk("alu_a", 32'(alu_a), 32'(mon_e.a));
          chk("alu_b_op", 32'({alu_b, alu_opcode}), 32'({mon_e.b, mon_e.op}));
        end
        mon_l.res = rsp_result;
        mon_l.acc = acc;
        mon_l.a   = alu_a;
        mon_l.c   = rsp_carry;
        mon_l.z   = rsp_zero;
        mon_l.cyc = cyc;
        log_q.push_back(mon_l);
      end
    end
    prev_hold = !rst && rsp_valid && !rsp_ready;
    prev_res  = rsp_result;
    prev_c    = rsp_carry;
    prev_z    = rsp_zero;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    int n;
    n = 0;
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout got=ready0 exp=ready1");
    end else begin
      model_push(op, a, b, ua);
    end
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic wait_log(input int n, output bit ok);
    int k;
    k = 0;
    while (log_q.size() < n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rsp_count", 32'(log_q.size()), 32'(n));
    ok = (log_q.size() >= n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp4 [5] = '{8'h01, 8'h8F, 8'h7E, 8'h02, 8'h40};
  logic [2:0] ops4 [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
  logic [7:0] exp5 [4] = '{8'h03, 8'h06, 8'h0B, 8'h30};

  initial begin
    bit ok;
    int acc_c;
    int acc_n;
    int cyc_n;
    bit took;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_use_acc = 1'b0;
    rsp_ready = 1'b0;
    tick(2);
    @(negedge clk);
    chk("ready_in_rst", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_result, rsp_carry, rsp_zero}), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    tick(1);

    // Single ADD with latency
    rsp_ready = 1'b1;
    log_q.delete();
    push(3'd0, 8'd10, 8'd5, 1'b0);
    acc_c = last_acc_cyc;
    wait_log(1, ok);
    if (ok) begin
      chk("add_latency", 32'(log_q[0].cyc - acc_c), 32'd2);
      chk("add_result", 32'(log_q[0].res), 32'd15);
      chk("add_flags", 32'({log_q[0].c, log_q[0].z}), 32'd0);
      chk("add_acc", 32'(log_q[0].acc), 32'd15);
    end

    // Overflow then accumulator-chained SUB
    log_q.delete();
    push(3'd0, 8'd200, 8'd100, 1'b0);
    push(3'd1, 8'd0, 8'd4, 1'b1);
    wait_log(2, ok);
    if (ok) begin
      chk("ovf_result", 32'(log_q[0].res), 32'd44);
      chk("ovf_carry", 32'(log_q[0].c), 32'd1);
      chk("chain_a", 32'(log_q[1].a), 32'd44);
      chk("chain_result", 32'(log_q[1].res), 32'd40);
    end

    // Zero flag
    log_q.delete();
    push(3'd4, 8'h5A, 8'h5A, 1'b0);
    push(3'd3, 8'h0F, 8'hF0, 1'b0);
    wait_log(2, ok);
    if (ok) begin
      chk("xor_result", 32'(log_q[0].res), 32'd0);
      chk("xor_zero", 32'(log_q[0].z), 32'd1);
      chk("or_result", 32'(log_q[1].res), 32'hFF);
      chk("or_zero", 32'(log_q[1].z), 32'd0);
    end

    // Full FIFO under backpressure, then in-order drain at one op per two cycles
    rsp_ready = 1'b0;
    log_q.delete();
    for (int i = 0; i < 5; i++) push(ops4[i], 8'h81, 8'h0F, 1'b0);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    tick(3);
    chk("full_hold_count", 32'(fifo_count), 32'd4);
    chk("full_hold_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    wait_log(5, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) chk("drain_result", 32'(log_q[i].res), 32'(exp4[i]));
      for (int i = 1; i < 5; i++) chk("drain_spacing", 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);
    end

    // Simultaneous push and pop
    rsp_ready = 1'b0;
    log_q.delete();
    push(3'd0, 8'd1, 8'd2, 1'b0);
    push(3'd1, 8'd9, 8'd3, 1'b0);
    push(3'd3, 8'd3, 8'd8, 1'b0);
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    chk("pp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready   = 1'b1;
    cmd_valid   = 1'b1;
    cmd_opcode  = 3'd2;
    cmd_a       = 8'hF0;
    cmd_b       = 8'h3C;
    cmd_use_acc = 1'b0;
    chk("pp_ready", 32'(cmd_ready), 32'd1);
    if (cmd_ready) model_push(3'd2, 8'hF0, 8'h3C, 1'b0);
    tick(1);
    cmd_valid = 1'b0;
    chk("pp_count_after", 32'(fifo_count), 32'd2);
    wait_log(4, ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) chk("pp_result", 32'(log_q[i].res), 32'(exp5[i]));
    end

    // Reset while in DRIVE with three entries queued
    rsp_ready = 1'b0;
    log_q.delete();
    for (int i = 0; i < 5; i++) push(3'd0, 8'(i + 1), 8'd16, 1'b0);
    chk("rq_count_full", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    tick(1);
    chk("rq_count_drive", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    exp_q.delete();
    acc_model = 8'h00;
    tick(1);
    rst = 1'b0;
    #1;
    chk("rq_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    chk("rq_rsp", 32'({rsp_valid, rsp_result, rsp_carry, rsp_zero}), 32'd0);
    chk("rq_acc", 32'(acc), 32'd0);
    chk("rq_count", 32'(fifo_count), 32'd0);
    chk("rq_ready", 32'(cmd_ready), 32'd1);
    log_q.delete();
    tick(10);
    chk("rq_no_stale", 32'(log_q.size()), 32'd0);
    push(3'd0, 8'h55, 8'd7, 1'b1);
    wait_log(1, ok);
    if (ok) chk("rq_acc_cleared", 32'(log_q[0].res), 32'd7);

    // Random phase: random commands, random valid gaps and random backpressure
    acc_n = 0;
    cyc_n = 0;
    took  = 1'b0;
    while (acc_n < 200 && cyc_n < 4000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && $urandom_range(0, 2) != 0) begin
        cmd_opcode  = 3'($urandom_range(0, 7));
        cmd_a       = 8'($urandom_range(0, 255));
        cmd_b       = ($urandom_range(0, 7) == 0) ? cmd_a : 8'($urandom_range(0, 255));
        cmd_use_acc = 1'($urandom_range(0, 1));
        cmd_valid   = 1'b1;
      end
      @(negedge clk);
      took = cmd_valid && cmd_ready;
      if (took) begin
        model_push(cmd_opcode, cmd_a, cmd_b, cmd_use_acc);
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (took) cmd_valid = 1'b0;
      cyc_n++;
      if (acc_n % 64 == 0) log_q.delete();
    end
    chk("rand_accepted", 32'(acc_n), 32'd200);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc_n = 0;
    while (exp_q.size() != 0 && cyc_n < 500) begin
      tick(1);
      cyc_n++;
    end
    tick(3);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("final_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
